alu_instr_sequencer: RTL and testbench

- Hardwired control unit for the phase-1 DataPath.
- Replaces hand-driven control pulses with a Moore FSM that fetches an instruction, decodes its opcode and steps the register/ALU control signals through T0..T6 for every ALU opcode.
- Drives register selection through Gra/Grb/Grc plus Rin/Rout; the select-and-encode logic is a separate block and is not part of this one.

---
 rtl/alu_instr_sequencer_pkg.sv | 70 +++++++
 rtl/alu_instr_sequencer_if.sv | 30 +++
 rtl/alu_instr_sequencer_decoder.sv | 20 ++
 rtl/alu_instr_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_instr_sequencer_pkg.sv
// Shared types and constants for the hardwired ALU instruction sequencer:
// FSM states, opcode encodings, alu_op bit positions and the control word.
package alu_seq_pkg;

    localparam int OPC_W   = 5;
    localparam int ALU_OPS = 13;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01011;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SHR  = 2;
    localparam int OP_SHRA = 3;
    localparam int OP_SHL  = 4;
    localparam int OP_ROR  = 5;
    localparam int OP_ROL  = 6;
    localparam int OP_AND  = 7;
    localparam int OP_OR   = 8;
    localparam int OP_MUL  = 9;
    localparam int OP_DIV  = 10;
    localparam int OP_NEG  = 11;
    localparam int OP_NOT  = 12;

    // Opcode that selects each alu_op bit, listed in alu_op bit order.
    localparam logic [OPC_W-1:0] OPC_BY_OP [ALU_OPS] = '{
        OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL,
        OPC_AND, OPC_OR, OPC_MUL, OPC_DIV, OPC_NEG, OPC_NOT
    };

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic run;
        logic [ALU_OPS-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bus between the sequencer (master) and the phase-1 datapath (slave).
interface alu_instr_sequencer_if;
    import alu_seq_pkg::*;

    logic                Start;
    logic                Stop;
    logic [31:0]         IR;
    logic                Mem_ready;
    logic                PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic                Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic                Gra, Grb, Grc, Rin, Rout;
    logic [ALU_OPS-1:0]  alu_op;
    logic                Run;
    logic                Illegal;

    modport master (
        input  Start, Stop, IR, Mem_ready,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Zhighout, HIin, LOin,
        output Gra, Grb, Grc, Rin, Rout, alu_op, Run, Illegal
    );

    modport slave (
        output Start, Stop, IR, Mem_ready,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Zhighout, HIin, LOin,
        input  Gra, Grb, Grc, Rin, Rout, alu_op, Run, Illegal
    );

endinterface

// File: rtl/alu_instr_sequencer_decoder.sv
// Combinational opcode decode: one-hot alu_op plus unary / mul-div / illegal class.
module alu_op_decoder
    import alu_seq_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    output logic [ALU_OPS-1:0] alu_op,
    output logic               is_unary,
    output logic               is_muldiv,
    output logic               illegal
);

    for (genvar gi = 0; gi < ALU_OPS; gi++) begin : g_match
        assign alu_op[gi] = (opcode == OPC_BY_OP[gi]);
    end

    assign is_unary  = alu_op[OP_NEG] | alu_op[OP_NOT];
    assign is_muldiv = alu_op[OP_MUL] | alu_op[OP_DIV];
    assign illegal   = ~|alu_op;

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control FSM stepping fetch (T0-T2) and ALU execute (T3-T6) for each opcode.
// Build option CTRL_MEM_WAIT_EN: T1 waits for Mem_ready before advancing.
module alu_instr_sequencer
    import alu_seq_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Clear,
    alu_instr_sequencer_if.master bus
);

    state_t             state_q, state_d;
    logic               stop_q, stop_d;
    logic               illegal_q, illegal_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    ctrl_t              ctrl_q, ctrl_d;

    logic [ALU_OPS-1:0] dec_alu_op;
    logic               dec_unary, dec_muldiv, dec_illegal;

    // Decode the opcode that will be current after this edge, so the
    // registered outputs for the next state already reflect it.
    alu_op_decoder u_dec (
        .opcode    (opc_d),
        .alu_op    (dec_alu_op),
        .is_unary  (dec_unary),
        .is_muldiv (dec_muldiv),
        .illegal   (dec_illegal)
    );

    state_t end_state;
    assign end_state = (stop_q || bus.Stop) ? S_HALT : S_T0;

    always_comb begin
        state_d   = state_q;
        stop_d    = stop_q | bus.Stop;
        illegal_d = illegal_q;
        opc_d     = opc_q;
        case (state_q)
            S_IDLE: if (bus.Start) state_d = S_T0;
            S_T0:   state_d = S_T1;
`ifdef CTRL_MEM_WAIT_EN
            S_T1:   if (bus.Mem_ready) state_d = S_T2;
`else
            S_T1:   state_d = S_T2;
`endif
            S_T2: begin
                state_d = S_T3;
                opc_d   = bus.IR[31:27];
            end
            S_T3: begin
                if (dec_illegal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4:   state_d = dec_unary ? end_state : S_T5;
            S_T5:   state_d = dec_muldiv ? S_T6 : end_state;
            S_T6:   state_d = end_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_HALT) stop_d = 1'b0;
    end

    always_comb begin
        ctrl_d     = '0;
        ctrl_d.run = (state_d != S_IDLE) && (state_d != S_HALT);
        case (state_d)
            S_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
                ctrl_d.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.pc_in    = 1'b1;
                ctrl_d.read     = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                // An undefined opcode idles here for one cycle before HALT.
                if (!dec_illegal) begin
                    ctrl_d.grb   = 1'b1;
                    ctrl_d.r_out = 1'b1;
                    if (dec_unary) begin
                        ctrl_d.alu_op = dec_alu_op;
                        ctrl_d.z_in   = 1'b1;
                    end else begin
                        ctrl_d.y_in = 1'b1;
                    end
                end
            end
            S_T4: begin
                if (dec_unary) begin
                    ctrl_d.zlow_out = 1'b1;
                    ctrl_d.gra      = 1'b1;
                    ctrl_d.r_in     = 1'b1;
                end else begin
                    ctrl_d.grc    = 1'b1;
                    ctrl_d.r_out  = 1'b1;
                    ctrl_d.alu_op = dec_alu_op;
                    ctrl_d.z_in   = 1'b1;
                end
            end
            S_T5: begin
                ctrl_d.zlow_out = 1'b1;
                if (dec_muldiv) begin
                    ctrl_d.lo_in = 1'b1;
                end else begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.r_in = 1'b1;
                end
            end
            S_T6: begin
                ctrl_d.zhigh_out = 1'b1;
                ctrl_d.hi_in     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q   <= S_IDLE;
            stop_q    <= 1'b0;
            illegal_q <= 1'b0;
            opc_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            illegal_q <= illegal_d;
            opc_q     <= opc_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign bus.PCout    = ctrl_q.pc_out;
    assign bus.MARin    = ctrl_q.mar_in;
    assign bus.IncPC    = ctrl_q.inc_pc;
    assign bus.PCin     = ctrl_q.pc_in;
    assign bus.Read     = ctrl_q.read;
    assign bus.MDRin    = ctrl_q.mdr_in;
    assign bus.MDRout   = ctrl_q.mdr_out;
    assign bus.IRin     = ctrl_q.ir_in;
    assign bus.Yin      = ctrl_q.y_in;
    assign bus.Zin      = ctrl_q.z_in;
    assign bus.Zlowout  = ctrl_q.zlow_out;
    assign bus.Zhighout = ctrl_q.zhigh_out;
    assign bus.HIin     = ctrl_q.hi_in;
    assign bus.LOin     = ctrl_q.lo_in;
    assign bus.Gra      = ctrl_q.gra;
    assign bus.Grb      = ctrl_q.grb;
    assign bus.Grc      = ctrl_q.grc;
    assign bus.Rin      = ctrl_q.r_in;
    assign bus.Rout     = ctrl_q.r_out;
    assign bus.alu_op   = ctrl_q.alu_op;
    assign bus.Run      = ctrl_q.run;
    assign bus.Illegal  = illegal_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed table-driven bench for alu_instr_sequencer plus hand-written
// sequences for illegal opcode, Stop, Clear mid-instruction and memory wait.
module tb_alu_instr_sequencer;

    logic Clock;
    logic Clear;

    alu_instr_sequencer_if bus_if ();

    alu_instr_sequencer dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus_if.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Observed control word bit positions.
    localparam logic [19:0] PCOUT  = 20'h80000;
    localparam logic [19:0] MARIN  = 20'h40000;
    localparam logic [19:0] INCPC  = 20'h20000;
    localparam logic [19:0] PCIN   = 20'h10000;
    localparam logic [19:0] READ   = 20'h08000;
    localparam logic [19:0] MDRIN  = 20'h04000;
    localparam logic [19:0] MDROUT = 20'h02000;
    localparam logic [19:0] IRIN   = 20'h01000;
    localparam logic [19:0] YIN    = 20'h00800;
    localparam logic [19:0] ZIN    = 20'h00400;
    localparam logic [19:0] ZLOW   = 20'h00200;
    localparam logic [19:0] ZHIGH  = 20'h00100;
    localparam logic [19:0] HIIN   = 20'h00080;
    localparam logic [19:0] LOIN   = 20'h00040;
    localparam logic [19:0] GRA    = 20'h00020;
    localparam logic [19:0] GRB    = 20'h00010;
    localparam logic [19:0] GRC    = 20'h00008;
    localparam logic [19:0] RIN    = 20'h00004;
    localparam logic [19:0] ROUT   = 20'h00002;
    localparam logic [19:0] RUN    = 20'h00001;

    localparam logic [19:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [19:0] F1 = ZLOW | PCIN | READ | MDRIN | RUN;
    localparam logic [19:0] F2 = MDROUT | IRIN | RUN;
    localparam logic [19:0] B3 = GRB | ROUT | YIN | RUN;
    localparam logic [19:0] B4 = GRC | ROUT | ZIN | RUN;
    localparam logic [19:0] W5 = ZLOW | GRA | RIN | RUN;
    localparam logic [19:0] M5 = ZLOW | LOIN | RUN;
    localparam logic [19:0] M6 = ZHIGH | HIIN | RUN;
    localparam logic [19:0] U3 = GRB | ROUT | ZIN | RUN;
    localparam logic [19:0] U4 = ZLOW | GRA | RIN | RUN;

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          len;
        logic [19:0] ctl [7];
        logic [12:0] alu [7];
    } vec_t;

    vec_t tbl [8];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [19:0] obs();
        return {bus_if.PCout, bus_if.MARin, bus_if.IncPC, bus_if.PCin, bus_if.Read,
                bus_if.MDRin, bus_if.MDRout, bus_if.IRin, bus_if.Yin, bus_if.Zin,
                bus_if.Zlowout, bus_if.Zhighout, bus_if.HIin, bus_if.LOin, bus_if.Gra,
                bus_if.Grb, bus_if.Grc, bus_if.Rin, bus_if.Rout, bus_if.Run};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic set_row(input int i, input string nm, input logic [31:0] ir, input int len,
                           input logic [19:0] c3, input logic [19:0] c4,
                           input logic [19:0] c5, input logic [19:0] c6,
                           input logic [12:0] a3, input logic [12:0] a4);
        tbl[i].name = nm;
        tbl[i].ir   = ir;
        tbl[i].len  = len;
        tbl[i].ctl  = '{F0, F1, F2, c3, c4, c5, c6};
        tbl[i].alu  = '{13'h0, 13'h0, 13'h0, a3, a4, 13'h0, 13'h0};
    endtask

    task automatic do_reset();
        Clear          = 1'b1;
        bus_if.Start   = 1'b0;
        bus_if.Stop    = 1'b0;
        bus_if.Mem_ready = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        bus_if.IR = 32'h0;
        set_row(0, "ADD", 32'h1A000000, 6, B3, B4, W5, 20'h0, 13'h0000, 13'h0001);
        set_row(1, "SUB", 32'h20000000, 6, B3, B4, W5, 20'h0, 13'h0000, 13'h0002);
        set_row(2, "ROR", 32'h50000000, 6, B3, B4, W5, 20'h0, 13'h0000, 13'h0020);
        set_row(3, "AND", 32'h28000000, 6, B3, B4, W5, 20'h0, 13'h0000, 13'h0080);
        set_row(4, "MUL", 32'h78000000, 7, B3, B4, M5, M6,    13'h0000, 13'h0200);
        set_row(5, "DIV", 32'h80000000, 7, B3, B4, M5, M6,    13'h0000, 13'h0400);
        set_row(6, "NOT", 32'h90000000, 5, U3, U4, 20'h0, 20'h0, 13'h1000, 13'h0000);
        set_row(7, "NEG", 32'h88000000, 5, U3, U4, 20'h0, 20'h0, 13'h0800, 13'h0000);

        // Reset state.
        do_reset();
        chk("reset_ctl", 32'(obs()), 32'h0);
        chk("reset_alu", 32'(bus_if.alu_op), 32'h0);
        chk("reset_illegal", 32'(bus_if.Illegal), 32'h0);
        tick();
        chk("idle_no_start", 32'(obs()), 32'h0);

        // Table: each instruction from IDLE, then the first step of the next fetch.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            bus_if.IR    = tbl[r].ir;
            bus_if.Start = 1'b1;
            for (int c = 0; c <= tbl[r].len; c++) begin
                tick();
                if (c < tbl[r].len) begin
                    chk($sformatf("%s_T%0d_ctl", tbl[r].name, c), 32'(obs()), 32'(tbl[r].ctl[c]));
                    chk($sformatf("%s_T%0d_alu", tbl[r].name, c), 32'(bus_if.alu_op), 32'(tbl[r].alu[c]));
                end else begin
                    chk($sformatf("%s_next_T0", tbl[r].name), 32'(obs()), 32'(F0));
                    chk($sformatf("%s_next_alu", tbl[r].name), 32'(bus_if.alu_op), 32'h0);
                end
            end
            chk($sformatf("%s_illegal", tbl[r].name), 32'(bus_if.Illegal), 32'h0);
            $display("vector %s ir=%h len=%0d checked", tbl[r].name, tbl[r].ir, tbl[r].len);
        end

        // Undefined opcode 11111: HALT after T3, sticky Illegal, Start ignored.
        do_reset();
        bus_if.IR    = 32'hF8000000;
        bus_if.Start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("ill_T%0d_nowrite", c), 32'(obs() & (RIN | HIIN | LOIN)), 32'h0);
            if (c < 3) chk($sformatf("ill_T%0d_ctl", c), 32'(obs()), 32'(tbl[0].ctl[c]));
        end
        for (int c = 4; c < 8; c++) begin
            tick();
            chk($sformatf("ill_halt%0d_ctl", c), 32'(obs()), 32'h0);
            chk($sformatf("ill_halt%0d_flag", c), 32'(bus_if.Illegal), 32'h1);
        end
        Clear = 1'b1;
        #1;
        chk("ill_clear_flag", 32'(bus_if.Illegal), 32'h0);
        chk("ill_clear_ctl", 32'(obs()), 32'h0);
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        tick();
        chk("ill_restart_T0", 32'(obs()), 32'(F0));
        $display("sequence illegal_opcode checked");

        // Stop pulsed in T1 of ADD: finish the instruction, then HALT.
        do_reset();
        bus_if.IR    = 32'h1A000000;
        bus_if.Start = 1'b1;
        tick();
        chk("stop_T0", 32'(obs()), 32'(F0));
        tick();
        chk("stop_T1", 32'(obs()), 32'(F1));
        bus_if.Stop = 1'b1;
        tick();
        bus_if.Stop = 1'b0;
        chk("stop_T2", 32'(obs()), 32'(F2));
        for (int c = 3; c < 6; c++) begin
            tick();
            chk($sformatf("stop_T%0d", c), 32'(obs()), 32'(tbl[0].ctl[c]));
        end
        for (int c = 6; c < 9; c++) begin
            tick();
            chk($sformatf("stop_halt%0d", c), 32'(obs()), 32'h0);
        end
        chk("stop_illegal", 32'(bus_if.Illegal), 32'h0);
        $display("sequence stop_in_T1 checked");

        // Clear during T4 of SUB: immediate abort.
        do_reset();
        bus_if.IR    = 32'h20000000;
        bus_if.Start = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("clr_T4_ctl", 32'(obs()), 32'(B4));
        chk("clr_T4_alu", 32'(bus_if.alu_op), 32'h0002);
        Clear = 1'b1;
        #1;
        chk("clr_async_ctl", 32'(obs()), 32'h0);
        chk("clr_async_alu", 32'(bus_if.alu_op), 32'h0);
        bus_if.Start = 1'b0;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        tick();
        chk("clr_idle", 32'(obs()), 32'h0);
        $display("sequence clear_in_T4 checked");

`ifdef CTRL_MEM_WAIT_EN
        // Mem_ready low for three cycles stretches T1 to four cycles.
        do_reset();
        bus_if.IR        = 32'h1A000000;
        bus_if.Mem_ready = 1'b0;
        bus_if.Start     = 1'b1;
        tick();
        chk("wait_T0", 32'(obs()), 32'(F0));
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("wait_T1_%0d", c), 32'(obs()), 32'(F1));
        end
        bus_if.Mem_ready = 1'b1;
        tick();
        chk("wait_T2", 32'(obs()), 32'(F2));
        $display("sequence mem_wait checked");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
